// File: rtl/t07_mmio_ctrl.sv
// CPU-side MMIO controller: decodes a latched request to wishbone, register or TFT targets and stalls the CPU until the target completes.
// Minimum 3 cycles request-to-idle (2 for illegal accesses); optional WAIT timeout under T07_MMIO_TIMEOUT_EN.
module t07_mmio_ctrl #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned INSTR_TOP   = 1024,
    parameter int unsigned REG_TOP     = 1056,
    parameter int unsigned DMEM_TOP    = 1792,
    parameter int unsigned TFT_TOP     = 2047,
    parameter logic [7:0]  WB_PREFIX   = 8'h33,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    input  logic [1:0]        cpu_rwi_i,
    output logic [DATA_W-1:0] cpu_instr_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_busy_o,
    output logic              cpu_err_o,
    input  logic [DATA_W-1:0] wb_data_i,
    input  logic              wb_busy_i,
    output logic              wb_read_o,
    output logic              wb_write_o,
    output logic [ADDR_W-1:0] wb_addr_o,
    output logic [DATA_W-1:0] wb_wdata_o,
    input  logic [DATA_W-1:0] reg_data_i,
    input  logic              reg_ack_i,
    output logic              reg_read_o,
    output logic [4:0]        reg_addr_o,
    input  logic              tft_ack_i,
    output logic              tft_write_o,
    output logic [ADDR_W-1:0] tft_addr_o,
    output logic [DATA_W-1:0] tft_data_o
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
    typedef enum logic [2:0] {R_INSTR, R_REG, R_DMEM, R_TFT, R_UNMAP} region_t;

    localparam logic [1:0]        RWI_FETCH = 2'b11;
    localparam logic [1:0]        RWI_LOAD  = 2'b10;
    localparam logic [1:0]        RWI_STORE = 2'b01;
    localparam logic [DATA_W-1:0] POISON    = DATA_W'(32'hDEADBEEF);

    function automatic region_t decode(input logic [ADDR_W-1:0] a);
        if (a <= ADDR_W'(INSTR_TOP))     return R_INSTR;
        else if (a <= ADDR_W'(REG_TOP))  return R_REG;
        else if (a <= ADDR_W'(DMEM_TOP)) return R_DMEM;
        else if (a <= ADDR_W'(TFT_TOP))  return R_TFT;
        else                             return R_UNMAP;
    endfunction

    function automatic logic is_legal(input logic [1:0] rwi, input region_t r);
        case (r)
            R_INSTR: return rwi != RWI_STORE;
            R_REG:   return rwi == RWI_LOAD;
            R_DMEM:  return rwi != RWI_FETCH;
            R_TFT:   return rwi == RWI_STORE;
            default: return 1'b0;
        endcase
    endfunction

    state_t      state_q, state_d;
    region_t     region_q;
    logic [1:0]  rwi_q;
    logic        legal_q;
    logic        seen_q;
    logic        err_q;
    logic [DATA_W-1:0] instr_q, rdata_q, wb_wdata_q, tft_data_q;
    logic [ADDR_W-1:0] wb_addr_q, tft_addr_q;
    logic [4:0]  reg_addr_q;

    region_t     dec_region;
    logic        dec_legal;
    logic        accept;
    logic        is_wb;
    logic        complete;
    logic        timeout;

    assign dec_region = decode(cpu_addr_i);
    assign dec_legal  = is_legal(cpu_rwi_i, dec_region);
    assign accept     = (state_q == S_IDLE) && (cpu_rwi_i != 2'b00);
    assign is_wb      = (region_q == R_INSTR) || (region_q == R_DMEM);

    // Wishbone completion needs a busy phase first, so a slave that is slow to raise busy is not mistaken for done.
    always_comb begin
        complete = 1'b0;
        if (state_q == S_WAIT) begin
            if (is_wb)                    complete = seen_q && !wb_busy_i;
            else if (region_q == R_REG)   complete = reg_ack_i;
            else                          complete = tft_ack_i;
        end
    end

`ifdef T07_MMIO_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q;

    assign timeout = (state_q == S_WAIT) && !complete && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst)                   cnt_q <= '0;
        else if (state_q == S_WAIT) cnt_q <= cnt_q + CNT_W'(1);
        else                       cnt_q <= '0;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_ISSUE;
            S_ISSUE: state_d = legal_q ? S_WAIT : S_DONE;
            S_WAIT:  if (complete || timeout) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cpu_busy_o  = accept || (state_q == S_ISSUE) || (state_q == S_WAIT);
        wb_read_o   = 1'b0;
        wb_write_o  = 1'b0;
        reg_read_o  = 1'b0;
        tft_write_o = 1'b0;
        if (state_q == S_ISSUE && legal_q) begin
            case (region_q)
                R_INSTR, R_DMEM: begin
                    wb_read_o  = (rwi_q != RWI_STORE);
                    wb_write_o = (rwi_q == RWI_STORE);
                end
                R_REG:   reg_read_o  = 1'b1;
                R_TFT:   tft_write_o = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            region_q   <= R_UNMAP;
            rwi_q      <= 2'b00;
            legal_q    <= 1'b0;
            seen_q     <= 1'b0;
            err_q      <= 1'b0;
            instr_q    <= POISON;
            rdata_q    <= POISON;
            wb_addr_q  <= '0;
            wb_wdata_q <= '0;
            reg_addr_q <= '0;
            tft_addr_q <= '0;
            tft_data_q <= '0;
        end else begin
            if (accept) begin
                region_q <= dec_region;
                rwi_q    <= cpu_rwi_i;
                legal_q  <= dec_legal;
                seen_q   <= 1'b0;
                err_q    <= 1'b0;
                // Only the selected target's bus is reloaded; the others keep their last transaction.
                if (dec_legal) begin
                    case (dec_region)
                        R_INSTR, R_DMEM: begin
                            wb_addr_q <= {WB_PREFIX, cpu_addr_i[ADDR_W-9:0]};
                            if (cpu_rwi_i == RWI_STORE) wb_wdata_q <= cpu_wdata_i;
                        end
                        R_REG: reg_addr_q <= cpu_addr_i[4:0];
                        R_TFT: begin
                            tft_addr_q <= cpu_addr_i;
                            tft_data_q <= cpu_wdata_i;
                        end
                        default: ;
                    endcase
                end
            end
            if ((state_q == S_ISSUE || state_q == S_WAIT) && wb_busy_i) seen_q <= 1'b1;
            if ((state_q == S_ISSUE && !legal_q) || timeout) begin
                err_q <= 1'b1;
                if (rwi_q == RWI_FETCH) instr_q <= POISON;
                else                    rdata_q <= POISON;
            end else if (complete) begin
                if (is_wb && rwi_q == RWI_FETCH)     instr_q <= wb_data_i;
                else if (is_wb && rwi_q == RWI_LOAD) rdata_q <= wb_data_i;
                else if (region_q == R_REG)          rdata_q <= reg_data_i;
            end
        end
    end

    assign cpu_err_o   = err_q;
    assign cpu_instr_o = instr_q;
    assign cpu_rdata_o = rdata_q;
    assign wb_addr_o   = wb_addr_q;
    assign wb_wdata_o  = wb_wdata_q;
    assign reg_addr_o  = reg_addr_q;
    assign tft_addr_o  = tft_addr_q;
    assign tft_data_o  = tft_data_q;

endmodule

// File: tb/tb_t07_mmio_ctrl.sv
// Randomized bench for t07_mmio_ctrl: a timeline model predicts every output each cycle, plus literal pins for the directed scenarios.
module tb_t07_mmio_ctrl;
    localparam int          TCYC = 8;
    localparam logic [31:0] BAD  = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cpu_addr_i, cpu_wdata_i;
    logic [1:0]  cpu_rwi_i;
    logic [31:0] cpu_instr_o, cpu_rdata_o;
    logic        cpu_busy_o, cpu_err_o;
    logic [31:0] wb_data_i;
    logic        wb_busy_i, wb_read_o, wb_write_o;
    logic [31:0] wb_addr_o, wb_wdata_o;
    logic [31:0] reg_data_i;
    logic        reg_ack_i, reg_read_o;
    logic [4:0]  reg_addr_o;
    logic        tft_ack_i, tft_write_o;
    logic [31:0] tft_addr_o, tft_data_o;

    always #5 clk = ~clk;

    t07_mmio_ctrl #(.TIMEOUT_CYC(TCYC)) dut (
        .clk(clk), .rst(rst),
        .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i), .cpu_rwi_i(cpu_rwi_i),
        .cpu_instr_o(cpu_instr_o), .cpu_rdata_o(cpu_rdata_o),
        .cpu_busy_o(cpu_busy_o), .cpu_err_o(cpu_err_o),
        .wb_data_i(wb_data_i), .wb_busy_i(wb_busy_i),
        .wb_read_o(wb_read_o), .wb_write_o(wb_write_o),
        .wb_addr_o(wb_addr_o), .wb_wdata_o(wb_wdata_o),
        .reg_data_i(reg_data_i), .reg_ack_i(reg_ack_i),
        .reg_read_o(reg_read_o), .reg_addr_o(reg_addr_o),
        .tft_ack_i(tft_ack_i), .tft_write_o(tft_write_o),
        .tft_addr_o(tft_addr_o), .tft_data_o(tft_data_o)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    logic        exp_busy, exp_err, exp_wb_rd, exp_wb_wr, exp_reg_rd, exp_tft_wr;
    logic [31:0] exp_instr, exp_rdata, exp_wb_addr, exp_wb_wdata, exp_tft_addr, exp_tft_data;
    logic [4:0]  exp_reg_addr;

    // Literal pins: bit 0 instr, 1 rdata, 2 wb_addr, 3 reg_addr, 4 tft_addr, 5 tft_data, 6 err, 7 busy.
    logic [7:0]  pin_mask = 8'h00;
    logic [31:0] pin_instr, pin_rdata, pin_wb_addr, pin_tft_addr, pin_tft_data;
    logic [4:0]  pin_reg_addr;
    logic        pin_err, pin_busy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",     32'(cpu_busy_o),  32'(exp_busy));
            chk("err",      32'(cpu_err_o),   32'(exp_err));
            chk("wb_read",  32'(wb_read_o),   32'(exp_wb_rd));
            chk("wb_write", 32'(wb_write_o),  32'(exp_wb_wr));
            chk("reg_read", 32'(reg_read_o),  32'(exp_reg_rd));
            chk("tft_write",32'(tft_write_o), 32'(exp_tft_wr));
            chk("instr",    cpu_instr_o,      exp_instr);
            chk("rdata",    cpu_rdata_o,      exp_rdata);
            chk("wb_addr",  wb_addr_o,        exp_wb_addr);
            chk("wb_wdata", wb_wdata_o,       exp_wb_wdata);
            chk("reg_addr", 32'(reg_addr_o),  32'(exp_reg_addr));
            chk("tft_addr", tft_addr_o,       exp_tft_addr);
            chk("tft_data", tft_data_o,       exp_tft_data);
            if (pin_mask[0]) chk("pin_instr",    cpu_instr_o,      pin_instr);
            if (pin_mask[1]) chk("pin_rdata",    cpu_rdata_o,      pin_rdata);
            if (pin_mask[2]) chk("pin_wb_addr",  wb_addr_o,        pin_wb_addr);
            if (pin_mask[3]) chk("pin_reg_addr", 32'(reg_addr_o),  32'(pin_reg_addr));
            if (pin_mask[4]) chk("pin_tft_addr", tft_addr_o,       pin_tft_addr);
            if (pin_mask[5]) chk("pin_tft_data", tft_data_o,       pin_tft_data);
            if (pin_mask[6]) chk("pin_err",      32'(cpu_err_o),   32'(pin_err));
            if (pin_mask[7]) chk("pin_busy",     32'(cpu_busy_o),  32'(pin_busy));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    // 0 INSTR, 1 REG, 2 DMEM, 3 TFT, 4 UNMAPPED
    function automatic int region_of(input logic [31:0] a);
        if (a <= 32'd1024)      return 0;
        else if (a <= 32'd1056) return 1;
        else if (a <= 32'd1792) return 2;
        else if (a <= 32'd2047) return 3;
        else                    return 4;
    endfunction

    function automatic bit legal(input logic [1:0] rwi, input int rg);
        case (rg)
            0: return rwi != 2'b01;
            1: return rwi == 2'b10;
            2: return rwi != 2'b11;
            3: return rwi == 2'b01;
            default: return 1'b0;
        endcase
    endfunction

    task automatic reset_exp();
        exp_busy = 0; exp_err = 0;
        exp_wb_rd = 0; exp_wb_wr = 0; exp_reg_rd = 0; exp_tft_wr = 0;
        exp_instr = BAD; exp_rdata = BAD;
        exp_wb_addr = 0; exp_wb_wdata = 0; exp_reg_addr = 0; exp_tft_addr = 0; exp_tft_data = 0;
    endtask

    task automatic rnd_rsp();
        wb_busy_i  = 1'($urandom);
        wb_data_i  = $urandom;
        reg_ack_i  = 1'($urandom);
        reg_data_i = $urandom;
        tft_ack_i  = 1'($urandom);
    endtask

    task automatic strobes_off();
        exp_wb_rd = 0; exp_wb_wr = 0; exp_reg_rd = 0; exp_tft_wr = 0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            pin_mask = 0;
            cpu_rwi_i = 2'b00; cpu_addr_i = $urandom; cpu_wdata_i = $urandom;
            rnd_rsp();
            exp_busy = 0;
            strobes_off();
        end
    endtask

    // Timeline: 0 request, 1 ISSUE, 2.. WAIT, completion at c, DONE one cycle later.
    // WB busy pattern from ISSUE: p low, h high, then low. REG/TFT ack a cycles after ISSUE.
    task automatic access(input logic [1:0] rwi, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rsp, input int p, input int h, input int a, input int rst_at);
        int rg, c, done_idx;
        bit ok, wb, to;
        rg = region_of(addr);
        ok = legal(rwi, rg);
        wb = (rg == 0) || (rg == 2);
        c  = wb ? 1 + p + h : 1 + a;
        to = 0;
        if (!ok) done_idx = 2;
        else begin
`ifdef T07_MMIO_TIMEOUT_EN
            if (c > TCYC + 1) begin to = 1; done_idx = TCYC + 2; end
            else done_idx = c + 1;
`else
            done_idx = c + 1;
`endif
        end
        @(posedge clk); #1;
        pin_mask = 0;
        cpu_rwi_i = rwi; cpu_addr_i = addr; cpu_wdata_i = wdata;
        rnd_rsp();
        exp_busy = 1;
        strobes_off();
        for (int i = 1; i <= done_idx; i++) begin
            @(posedge clk); #1;
            if (rst_at != 0 && i == rst_at + 1) begin
                rst = 0;
                cpu_rwi_i = 2'b00;
                reset_exp();
                return;
            end
            rnd_rsp();
            if (i < done_idx) begin
                cpu_rwi_i = 2'($urandom); cpu_addr_i = $urandom; cpu_wdata_i = $urandom;
            end else begin
                cpu_rwi_i = 2'b00;
            end
            if (ok && i <= c) begin
                if (wb)      wb_busy_i = (i - 1 >= p) && (i - 1 < p + h);
                if (rg == 1) reg_ack_i = (i == 1) || (i == c);
                if (rg == 3) tft_ack_i = (i == 1) || (i == c);
                if (i == c) begin wb_data_i = rsp; reg_data_i = rsp; end
            end
            strobes_off();
            if (i == 1 && ok) begin
                if (wb) begin
                    exp_wb_addr = {8'h33, addr[23:0]};
                    if (rwi == 2'b01) begin exp_wb_wr = 1; exp_wb_wdata = wdata; end
                    else exp_wb_rd = 1;
                end else if (rg == 1) begin
                    exp_reg_rd = 1; exp_reg_addr = addr[4:0];
                end else begin
                    exp_tft_wr = 1; exp_tft_addr = addr; exp_tft_data = wdata;
                end
            end
            if (i < done_idx) begin
                exp_busy = 1; exp_err = 0;
            end else begin
                exp_busy = 0;
                exp_err  = !ok || to;
                if (!ok || to) begin
                    if (rwi == 2'b11) exp_instr = BAD; else exp_rdata = BAD;
                end else if (rwi == 2'b11) exp_instr = rsp;
                else if (rwi == 2'b10)     exp_rdata = rsp;
            end
            if (rst_at == i) rst = 1;
        end
    endtask

    logic [31:0] bnd [10] = '{32'd0, 32'd1024, 32'd1025, 32'd1056, 32'd1057,
                              32'd1792, 32'd1793, 32'd2047, 32'd2048, 32'hFFFF_FFFF};

    initial begin
        logic [31:0] ra;
        rst = 1;
        cpu_rwi_i = 0; cpu_addr_i = 0; cpu_wdata_i = 0;
        wb_busy_i = 0; wb_data_i = 0; reg_ack_i = 0; reg_data_i = 0; tft_ack_i = 0;
        @(posedge clk); #1;
        reset_exp();
        chk_en = 1;
        pin_mask = 8'b1000_0111;
        pin_instr = BAD; pin_rdata = BAD; pin_wb_addr = 0; pin_busy = 0;
        @(posedge clk); #1;
        rst = 0;
        pin_mask = 0;

        access(2'b11, 32'h100, 32'h0, 32'h00A00093, 0, 2, 0, 0);
        pin_mask = 8'b0100_0101;
        pin_instr = 32'h00A00093; pin_wb_addr = 32'h33000100; pin_err = 0;

        access(2'b10, 32'd1030, 32'h0, 32'h12345678, 0, 0, 4, 0);
        pin_mask = 8'b0100_1010;
        pin_rdata = 32'h12345678; pin_reg_addr = 5'd6; pin_err = 0;

        access(2'b01, 32'd1800, 32'hCAFE0001, 32'h0, 0, 0, 1, 0);
        pin_mask = 8'b0011_0000;
        pin_tft_addr = 32'd1800; pin_tft_data = 32'hCAFE0001;

        access(2'b01, 32'd1040, 32'h5555AAAA, 32'h0, 0, 0, 0, 0);
        pin_mask = 8'b1100_0010;
        pin_rdata = BAD; pin_err = 1; pin_busy = 0;
        idle(1);

        access(2'b10, 32'd4096, 32'h0, 32'h0, 0, 0, 0, 0);
        pin_mask = 8'b1100_0010;
        pin_rdata = BAD; pin_err = 1; pin_busy = 0;

        access(2'b10, 32'd1100, 32'h0, 32'h0BADF00D, 0, 40, 0, 0);
        pin_mask = 8'b0100_0010;
`ifdef T07_MMIO_TIMEOUT_EN
        pin_rdata = BAD; pin_err = 1;
`else
        pin_rdata = 32'h0BADF00D; pin_err = 0;
`endif

        access(2'b01, 32'd1200, 32'h11223344, 32'h0, 0, 40, 0, 4);
        pin_mask = 8'b1100_0111;
        pin_instr = BAD; pin_rdata = BAD; pin_wb_addr = 0; pin_err = 0; pin_busy = 0;

        for (int n = 0; n < 160; n++) begin
            if ($urandom_range(0, 1) == 0) ra = bnd[$urandom_range(0, 9)];
            else if ($urandom_range(0, 3) != 0) ra = 32'($urandom_range(0, 2100));
            else ra = $urandom;
            access(2'($urandom_range(1, 3)), ra, $urandom, $urandom,
                   $urandom_range(0, 2), $urandom_range(1, 8), $urandom_range(1, 10), 0);
            idle($urandom_range(0, 2));
        end

        idle(2);
        @(negedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
